// File: rtl/pagerank_pkg.sv
// Shared types for the PageRank stream accumulator: Q32.32 rank, node index, FSM state.
package pagerank_pkg;

  typedef logic [63:0] rank_t;
  typedef logic [31:0] node_id_t;

  typedef enum logic [1:0] {
    ACC_IDLE    = 2'd0,
    ACC_RECEIVE = 2'd1,
    ACC_DONE    = 2'd2
  } acc_state_t;

  localparam rank_t RANK_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/dmp_acc_add.sv
// Combinational 64-bit rank adder; saturates at all-ones with DMP_ACC_SATURATE_EN,
// otherwise wraps modulo 2^64.
module dmp_acc_add
  import pagerank_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] sum_o
);

`ifdef DMP_ACC_SATURATE_EN
  logic [64:0] full;

  assign full  = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o = full[64] ? RANK_MAX : full[63:0];
`else
  assign sum_o = a_i + b_i;
`endif

endmodule

// File: rtl/dmp_stream_accumulator.sv
// Per-node Q32.32 stream accumulator: one beat per cycle, result visible next cycle, no backpressure.
// Adds saturate when DMP_ACC_SATURATE_EN is defined, otherwise they wrap.
module dmp_stream_accumulator
  import pagerank_pkg::*;
#(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        next_iteration,
  input  logic        stream_start,
  input  logic        stream_valid,
  input  logic [31:0] stream_node_id,
  input  logic [63:0] stream_data,
  input  logic        stream_done,
  output logic [63:0] acc_rank [NODES_IN_GRAPH],
  output logic        acc_valid,
  output logic        busy,
  output logic        err_range,
  output logic        err_count
);

  localparam int CW = $clog2(NUM_HW_THREADS + 1) + 1;
  localparam int IW = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_EXP = CW'(NUM_HW_THREADS);

  acc_state_t      state_q, state_d;
  rank_t           acc_q [NODES_IN_GRAPH];
  rank_t           acc_d [NODES_IN_GRAPH];
  logic [CW-1:0]   cnt_q [NODES_IN_GRAPH];
  logic [CW-1:0]   cnt_d [NODES_IN_GRAPH];
  logic            err_range_q, err_range_d;
  logic            err_count_q, err_count_d;

  logic            in_range;
  logic            beat_rx;
  logic            beat_ok;
  logic [IW-1:0]   beat_idx;
  rank_t           add_sum;
  logic            any_mismatch;

  assign in_range = stream_node_id < node_id_t'(NODES_IN_GRAPH);
  assign beat_rx  = (state_q == ACC_RECEIVE) && stream_valid;
  assign beat_ok  = beat_rx && in_range;
  assign beat_idx = stream_node_id[IW-1:0];

  dmp_acc_add u_add (
    .a_i   (acc_q[beat_idx]),
    .b_i   (stream_data),
    .sum_o (add_sum)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    err_range_d  = err_range_q;
    err_count_d  = err_count_q;
    any_mismatch = 1'b0;

    if (beat_ok) begin
      acc_d[beat_idx] = add_sum;
      if (cnt_q[beat_idx] != CNT_MAX) begin
        cnt_d[beat_idx] = cnt_q[beat_idx] + 1'b1;
      end
    end
    if (beat_rx && !in_range) begin
      err_range_d = 1'b1;
    end

    // Counts are judged after folding in a beat that arrives with stream_done.
    for (int i = 0; i < NODES_IN_GRAPH; i++) begin
      if (cnt_d[i] != CNT_EXP) begin
        any_mismatch = 1'b1;
      end
    end

    case (state_q)
      ACC_IDLE: begin
        if (stream_start) begin
          state_d = ACC_RECEIVE;
        end
      end
      ACC_RECEIVE: begin
        if (stream_done) begin
          state_d     = ACC_DONE;
          err_count_d = any_mismatch;
        end
      end
      ACC_DONE: begin
        state_d = ACC_DONE;
      end
      default: begin
        state_d = ACC_IDLE;
      end
    endcase

    // next_iteration overrides everything, including a same-cycle start or beat.
    if (next_iteration) begin
      state_d     = ACC_IDLE;
      err_range_d = 1'b0;
      err_count_d = 1'b0;
      for (int i = 0; i < NODES_IN_GRAPH; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACC_IDLE;
      err_range_q <= 1'b0;
      err_count_q <= 1'b0;
      for (int i = 0; i < NODES_IN_GRAPH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      err_range_q <= err_range_d;
      err_count_q <= err_count_d;
      for (int i = 0; i < NODES_IN_GRAPH; i++) begin
        acc_q[i] <= acc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign acc_rank  = acc_q;
  assign acc_valid = (state_q == ACC_DONE);
  assign busy      = (state_q == ACC_RECEIVE);
  assign err_range = err_range_q;
  assign err_count = err_count_q;

endmodule
